// File: rtl/fifo_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_word_packer_pkg
//   Shared helpers for the FIFO word packer.
//   - cnt_width:  bits needed to hold an entry count of 0..pack_ratio.
//   - slot_slice: maps the logical slot (pop order) to the slice of the
//                 packed output word that the entry occupies.
// -----------------------------------------------------------------------------
package fifo_word_packer_pkg;

  // Width of a counter able to hold 0..pack_ratio inclusive.
  function automatic int cnt_width(input int pack_ratio);
    return $clog2(pack_ratio + 1);
  endfunction

  // Slot k is the k-th entry popped. With lsb_first the first entry lands in
  // the lowest slice; otherwise the first entry lands in the top slice.
  function automatic int slot_slice(input int slot, input int pack_ratio,
                                    input bit lsb_first);
    if (lsb_first) begin
      return slot;
    end else begin
      return pack_ratio - 1 - slot;
    end
  endfunction

endpackage

// File: rtl/fifo_single_clk.sv
// -----------------------------------------------------------------------------
// fifo_single_clk
//   Single-clock FIFO with a registered read port: buf_out carries the popped
//   entry the cycle after rd_en is sampled high with the FIFO non-empty.
//   DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   wr_en      push buf_in (ignored while buf_full)
//   buf_in     write data
//   rd_en      pop request (ignored while buf_empty)
//   buf_out    read data, registered
//   buf_empty  no entries stored
//   buf_full   DEPTH entries stored
// -----------------------------------------------------------------------------
module fifo_single_clk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] buf_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] buf_out,
  output logic             buf_empty,
  output logic             buf_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign buf_empty = (count == (AW+1)'(0));
  assign buf_full  = (count == (AW+1)'(DEPTH));
  assign do_wr     = wr_en && !buf_full;
  assign do_rd     = rd_en && !buf_empty;

  // Storage array; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= buf_in;
    end
  end

  // Pointers, occupancy and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      buf_out <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + AW'(1);
      end
      if (do_rd) begin
        buf_out <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//   Pops FIFO_WIDTH-bit entries from an upstream FIFO and packs PACK_RATIO
//   consecutive entries into one wide word presented on a valid/ready port.
//   A flush pulse forces out a partially filled word (unused slots zeroed).
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en was high
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop request (combinational)
//   flush       single-cycle request to emit the partial word
//   out_data    packed word (registered)
//   out_count   number of valid entries in out_data (registered)
//   out_valid   out_data/out_count valid (registered)
//   out_ready   consumer accepts when out_valid && out_ready
//   busy        read pending, partial word held, or flush outstanding
// -----------------------------------------------------------------------------
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             fifo_data,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  input  logic                              flush,
  output logic [FIFO_WIDTH*PACK_RATIO-1:0]  out_data,
  output logic [cnt_width(PACK_RATIO)-1:0]  out_count,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy
);

  localparam int              CW       = cnt_width(PACK_RATIO);
  localparam int              WW       = FIFO_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0]   FULL_CNT = CW'(PACK_RATIO);

  // Accumulator stored in pop order: slot k occupies acc[k*FIFO_WIDTH +: FIFO_WIDTH].
  // The LSB_FIRST mapping is applied only when the word is copied out.
  logic [WW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          flush_req;

  logic          out_free;
  logic          full;
  logic          flush_go;
  logic          xfer;
  logic          flush_done;
  logic [CW-1:0] eff_cnt;
  logic [CW:0]   demand;
  logic [WW-1:0] packed_word;

  // Transfer decision and pop request. eff_cnt is the fill level after any
  // transfer this cycle, so a full word that leaves frees room for new pops.
  always_comb begin
    out_free   = !out_valid || out_ready;
    full       = (cnt == FULL_CNT);
    flush_go   = flush_req && !pend && (cnt != CW'(0));
    xfer       = out_free && (full || flush_go);
    eff_cnt    = xfer ? CW'(0) : cnt;
    // Entries already held plus the one still in flight must leave room.
    demand     = {1'b0, eff_cnt} + {{CW{1'b0}}, pend};
    fifo_rd_en = !fifo_empty && !flush_req && (demand < (CW+1)'(PACK_RATIO));
    // A flush completes on its own partial transfer, or immediately when
    // nothing is held or in flight. A full-word transfer does not end it.
    flush_done = (xfer && !full) || ((cnt == CW'(0)) && !pend);
    busy       = pend || (cnt != CW'(0)) || flush_req;
  end

  // Build the outgoing word: slots at or beyond cnt are zeroed, and each
  // populated slot is routed to its LSB_FIRST-dependent slice.
  always_comb begin
    packed_word = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (CW'(k) < cnt) begin
        packed_word[slot_slice(k, PACK_RATIO, LSB_FIRST)*FIFO_WIDTH +: FIFO_WIDTH] =
          acc[k*FIFO_WIDTH +: FIFO_WIDTH];
      end else begin
        packed_word[slot_slice(k, PACK_RATIO, LSB_FIRST)*FIFO_WIDTH +: FIFO_WIDTH] =
          '0;
      end
    end
  end

  // Accumulator fill: the entry returned for last cycle's pop lands in the
  // first free slot after any transfer happening this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
      if (pend) begin
        for (int k = 0; k < PACK_RATIO; k++) begin
          if (eff_cnt == CW'(k)) begin
            acc[k*FIFO_WIDTH +: FIFO_WIDTH] <= fifo_data;
          end
        end
        cnt <= eff_cnt + CW'(1);
      end else begin
        cnt <= eff_cnt;
      end
    end
  end

  // Flush request latch; a new flush while one is outstanding is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_req <= 1'b0;
    end else if (flush_req) begin
      if (flush_done) begin
        flush_req <= 1'b0;
      end else begin
        flush_req <= 1'b1;
      end
    end else begin
      flush_req <= flush;
    end
  end

  // Output register: loaded on transfer, cleared on acceptance, otherwise
  // held so data and count stay stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= packed_word;
      out_count <= cnt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//   Two packers (LSB_FIRST=1 and LSB_FIRST=0), each fed by its own FIFO with
//   identical write stimulus. Expected words go into per-instance queues when
//   stimulus is issued; negedge monitors pop and compare on every handshake.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int FW = 8;
  localparam int PR = 4;
  localparam int WW = FW * PR;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [FW-1:0] buf_in = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic [FW-1:0] fdata_a, fdata_b;
  logic          fempty_a, fempty_b, ffull_a, ffull_b;
  logic          rd_en_a, rd_en_b;
  logic [WW-1:0] out_data_a, out_data_b;
  logic [CW-1:0] out_count_a, out_count_b;
  logic          out_valid_a, out_valid_b;
  logic          busy_a, busy_b;

  always #5 clk = ~clk;

  fifo_single_clk #(.WIDTH(FW), .DEPTH(16)) u_fifo_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en_a),
    .buf_out(fdata_a), .buf_empty(fempty_a), .buf_full(ffull_a));

  fifo_single_clk #(.WIDTH(FW), .DEPTH(16)) u_fifo_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in), .rd_en(rd_en_b),
    .buf_out(fdata_b), .buf_empty(fempty_b), .buf_full(ffull_b));

  fifo_word_packer #(.FIFO_WIDTH(FW), .PACK_RATIO(PR), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fifo_data(fdata_a), .fifo_empty(fempty_a),
    .fifo_rd_en(rd_en_a), .flush(flush), .out_data(out_data_a),
    .out_count(out_count_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a));

  fifo_word_packer #(.FIFO_WIDTH(FW), .PACK_RATIO(PR), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fifo_data(fdata_b), .fifo_empty(fempty_b),
    .fifo_rd_en(rd_en_b), .flush(flush), .out_data(out_data_b),
    .out_count(out_count_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b));

  int tests = 0;
  int fails = 0;
  logic [CW+WW-1:0] exp_a[$];
  logic [CW+WW-1:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [FW-1:0] b);
    wr_en  = 1'b1;
    buf_in = b;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic expect_word(input logic [WW-1:0] wa, input logic [WW-1:0] wb,
                             input logic [CW-1:0] c);
    exp_a.push_back({c, wa});
    exp_b.push_back({c, wb});
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_a.size() + exp_b.size()), 64'd0);
  endtask

  // Scoreboard monitor for the LSB-first instance.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word_a: unexpected word %0h count %0d", out_data_a, out_count_a);
      end else begin
        check("word_a", 64'({out_count_a, out_data_a}), 64'(exp_a.pop_front()));
      end
    end
  end

  // Scoreboard monitor for the MSB-first instance.
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word_b: unexpected word %0h count %0d", out_data_b, out_count_b);
      end else begin
        check("word_b", 64'({out_count_b, out_data_b}), 64'(exp_b.pop_front()));
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_hold;
    int bad_rd;
    int bad_valid;
    logic [FW-1:0] b;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data",  64'(out_data_a),  64'd0);
    check("rst_out_count", 64'(out_count_a), 64'd0);
    check("rst_busy",      64'(busy_a),      64'd0);
    check("rst_rd_en",     64'(rd_en_a),     64'd0);
    rst = 1'b0;
    tick();

    // Basic pack
    out_ready = 1'b1;
    expect_word(32'h55AAF0B3, 32'hB3F0AA55, 3'd4);
    write_byte(8'hB3);
    write_byte(8'hF0);
    write_byte(8'hAA);
    write_byte(8'h55);
    drain(40, "basic_drain");
    repeat (3) tick();
    check("basic_idle_busy", 64'(busy_a), 64'd0);

    // Back-pressure
    out_ready = 1'b0;
    expect_word(32'h04030201, 32'h01020304, 3'd4);
    expect_word(32'h08070605, 32'h05060708, 3'd4);
    expect_word(32'h0C0B0A09, 32'h090A0B0C, 3'd4);
    for (int i = 1; i <= 12; i++) begin
      b = 8'(i);
      write_byte(b);
    end
    repeat (10) tick();
    bad_hold = 0;
    bad_rd   = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid_a === 1'b1 && out_data_a === 32'h04030201 && out_count_a === 3'd4))
        bad_hold++;
      if (out_data_b !== 32'h01020304) bad_hold++;
      if (rd_en_a !== 1'b0) bad_rd++;
    end
    check("bp_hold_stable", 64'(bad_hold), 64'd0);
    check("bp_rd_en_low",   64'(bad_rd),   64'd0);
    check("bp_fifo_nonempty", 64'(fempty_a), 64'd0);
    tick();
    out_ready = 1'b1;
    drain(60, "bp_drain");
    repeat (5) tick();

    // Flush partial
    expect_word(32'h00AAF0B3, 32'hB3F0AA00, 3'd3);
    write_byte(8'hB3);
    write_byte(8'hF0);
    write_byte(8'hAA);
    repeat (6) tick();
    check("flush_pre_valid", 64'(out_valid_a), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_hold", 64'(busy_a), 64'd1);
    tick();
    check("flush_busy_drop", 64'(busy_a), 64'd0);
    drain(10, "flush_drain");

    // Flush idle
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush_busy", 64'(busy_a), 64'd1);
    tick();
    check("idle_flush_clear", 64'(busy_a), 64'd0);
    bad_valid = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) bad_valid++;
    end
    check("idle_flush_no_valid", 64'(bad_valid), 64'd0);
    tick();

    // Empty guard
    bad_rd    = 0;
    bad_valid = 0;
    repeat (50) begin
      @(negedge clk);
      if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) bad_rd++;
      if (out_valid_a !== 1'b0) bad_valid++;
    end
    check("empty_rd_en", 64'(bad_rd), 64'd0);
    check("empty_valid", 64'(bad_valid), 64'd0);
    tick();

    // Reset mid-word
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (4) tick();
    check("mid_busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      64'(busy_a),      64'd0);
    check("mid_rst_valid",     64'(out_valid_a), 64'd0);
    check("mid_rst_count",     64'(out_count_a), 64'd0);
    check("mid_rst_data",      64'(out_data_a),  64'd0);
    check("mid_rst_rd_en",     64'(rd_en_a),     64'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_word(32'hA4A3A2A1, 32'hA1A2A3A4, 3'd4);
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    write_byte(8'hA4);
    drain(40, "post_rst_drain");

    // Idle tail so any duplicate word reaches the monitors.
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer for the single-clock FIFO. Pops FIFO_WIDTH-bit entries by driving the FIFO read enable, then packs PACK_RATIO consecutive entries into one wide word. The word is presented on a valid/ready output port. A flush input forces out a partially filled word.

## Interface
Parameters:
- FIFO_WIDTH, 8, width of one FIFO entry
- PACK_RATIO, 4, entries per output word (≥2)
- LSB_FIRST, 1, 1: first entry popped lands in bits [FIFO_WIDTH-1:0]; 0: first entry lands in the top slice

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_data  in  FIFO_WIDTH  FIFO read data, valid the cycle after fifo_rd_en is sampled high
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request (combinational)
- flush  in  1  single-cycle request to emit the partial word
- out_data  out  FIFO_WIDTH*PACK_RATIO  packed word (registered)
- out_count  out  $clog2(PACK_RATIO+1)  number of valid entries in out_data
- out_valid  out  1  out_data/out_count valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  read pending, partial word held, or flush outstanding

## Operation
- Internal state:
  - acc: PACK_RATIO slots
  - cnt: 0..PACK_RATIO
  - pend: a pop was issued last cycle
  - flush_req
  - output register
- out_free = !out_valid || out_ready.
- xfer = out_free && ((cnt==PACK_RATIO) || (flush_req && !pend && cnt!=0)).
- eff_cnt = xfer ? 0 : cnt.
- fifo_rd_en = !fifo_empty && !flush_req && (eff_cnt + pend) < PACK_RATIO.
- pend <= fifo_rd_en.
- When pend is high, fifo_data is written into slot eff_cnt, then cnt <= eff_cnt+1. Otherwise cnt <= eff_cnt.
- On xfer:
  - out_data <= acc, with slots ≥ cnt forced to 0.
  - out_count <= cnt.
  - out_valid <= 1.
- When out_valid && out_ready and there is no xfer, out_valid <= 0.
- flush sets flush_req. flush_req clears on its xfer, or in any cycle with cnt==0 && !pend, in which case no output is produced.
- While flush_req is set, no pops are issued.
- flush arriving while flush_req is already set has no further effect.
- A full word (cnt==PACK_RATIO) always transfers with priority over a flush. flush_req then stays set and drains the remainder.
- The FIFO is never popped while fifo_empty is high. Underflow is impossible.
- busy = pend || cnt!=0 || flush_req.

## Timing
- Reset values:
  - fifo_rd_en=0 (no pop while fifo_empty)
  - out_valid=0, out_data=0, out_count=0, busy=0
  - cnt=0, pend=0, flush_req=0
- Latency: first pop at cycle 0 → full word on out_valid at cycle PACK_RATIO+1.
- Sustained throughput: one word per PACK_RATIO+1 cycles, with a non-empty FIFO and out_ready held high.
- out_data and out_count hold stable while out_valid && !out_ready.
- Back-pressure is absorbed by one full acc plus the output register. With cnt==PACK_RATIO and out_valid && !out_ready, fifo_rd_en stays 0.
- rst asserted mid-word: all state clears immediately.
  - Popped but unemitted entries are discarded.
  - The FIFO is reset together with this block.

## Structure
- Shared package/header: function computing count width ($clog2(PACK_RATIO+1)) and the LSB_FIRST slot-index mapping.
- No sub-module; a single flat module.
- Bench instantiates fifo_single_clk upstream, wired as:
  - buf_out → fifo_data
  - buf_empty → fifo_empty
  - fifo_rd_en → rd_en

## Test plan
- Basic pack: write B3, F0, AA, 55; hold out_ready=1 → one word 0x55AAF0B3, out_count=4. With LSB_FIRST=0, expect 0xB3F0AA55.
- Back-pressure: write 12 bytes 0x01..0x0C; hold out_ready=0 for 20 cycles →
  - out_valid held with 0x04030201 stable;
  - fifo_rd_en stays 0 once acc is full;
  - after release: 0x08070605, then 0x0C0B0A09, with no loss or duplication.
- Flush partial: write B3, F0, AA; pulse flush after the third pop → 0x00AAF0B3, out_count=3; busy drops the next cycle.
- Flush idle: flush with an empty FIFO and cnt=0 → no out_valid; flush_req clears in 1 cycle.
- Empty guard: FIFO empty for 50 cycles → fifo_rd_en never high; out_valid stays 0.
- Reset mid-word: assert rst after 2 pops → all outputs return to reset values immediately. Fresh data after reset packs from slot 0.
